// File: rtl/alu_ctrl_pipe.sv
// Elastic STAGES-deep decode pipeline: opcode -> ALU op class, illegal flag and optional M-ext flag,
// plus a saturating counter of delivered illegal instructions. Define ALU_CTRL_MEXT_EN to decode MUL/DIV.
module alu_ctrl_pipe #(
   parameter int STAGES = 2,
   parameter int TAG_W  = 5,
   parameter int CNT_W  = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [6:0]       opcode_i,
   input  logic [6:0]       funct7_i,
   input  logic [TAG_W-1:0] tag_i,
   input  logic             flush_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [2:0]       aluop_o,
   output logic             illegal_o,
   output logic             mext_o,
   output logic [TAG_W-1:0] tag_o,
   output logic [CNT_W-1:0] illegal_cnt_o
);

   localparam int LAST = STAGES - 1;

   logic [STAGES-1:0] valid_q, valid_d, en, adv;
   logic [2:0]        aluop_q   [STAGES];
   logic [2:0]        aluop_d   [STAGES];
   logic              illegal_q [STAGES];
   logic              illegal_d [STAGES];
   logic              mext_q    [STAGES];
   logic              mext_d    [STAGES];
   logic [TAG_W-1:0]  tag_q     [STAGES];
   logic [TAG_W-1:0]  tag_d     [STAGES];
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [2:0] dec_aluop;
   logic       dec_illegal;
   logic       dec_mext;

   always_comb begin
      dec_aluop   = 3'b000;
      dec_illegal = 1'b0;
      dec_mext    = 1'b0;
      case (opcode_i)
         7'b0110011: begin
            if (funct7_i == 7'b0000001) begin
`ifdef ALU_CTRL_MEXT_EN
               dec_mext    = 1'b1;
`else
               dec_illegal = 1'b1;
`endif
            end
         end
         7'b0010011: dec_aluop = 3'b001;
         7'b1100011: dec_aluop = 3'b010;
         7'b1100111: dec_aluop = 3'b011;
         7'b1101111: dec_aluop = 3'b011;
         7'b0000011: dec_aluop = 3'b100;
         7'b0100011: dec_aluop = 3'b101;
         7'b0110111: dec_aluop = 3'b110;
         7'b0010111: dec_aluop = 3'b111;
         default:    dec_illegal = 1'b1;
      endcase
   end

   // Backpressure ripples from the output stage toward the input, one stage per loop step.
   always_comb begin
      logic en_next;
      en      = '0;
      adv     = '0;
      en_next = ready_i;
      for (int k = STAGES - 1; k >= 0; k--) begin
         adv[k]  = valid_q[k] & en_next;
         en[k]   = ~valid_q[k] | adv[k];
         en_next = en[k];
      end
   end

   always_comb begin
      valid_d = valid_q;
      for (int k = 0; k < STAGES; k++) begin
         aluop_d[k]   = aluop_q[k];
         illegal_d[k] = illegal_q[k];
         mext_d[k]    = mext_q[k];
         tag_d[k]     = tag_q[k];
      end
      if (en[0]) begin
         valid_d[0] = valid_i;
         if (valid_i) begin
            aluop_d[0]   = dec_aluop;
            illegal_d[0] = dec_illegal;
            mext_d[0]    = dec_mext;
            tag_d[0]     = tag_i;
         end
      end
      for (int k = 1; k < STAGES; k++) begin
         if (en[k]) begin
            valid_d[k] = valid_q[k-1];
            if (valid_q[k-1]) begin
               aluop_d[k]   = aluop_q[k-1];
               illegal_d[k] = illegal_q[k-1];
               mext_d[k]    = mext_q[k-1];
               tag_d[k]     = tag_q[k-1];
            end
         end
      end
      if (flush_i) valid_d = '0;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (adv[LAST] && illegal_q[LAST] && !flush_i && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         cnt_q   <= '0;
         for (int k = 0; k < STAGES; k++) begin
            aluop_q[k]   <= 3'b000;
            illegal_q[k] <= 1'b0;
            mext_q[k]    <= 1'b0;
            tag_q[k]     <= '0;
         end
      end else begin
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         for (int k = 0; k < STAGES; k++) begin
            aluop_q[k]   <= aluop_d[k];
            illegal_q[k] <= illegal_d[k];
            mext_q[k]    <= mext_d[k];
            tag_q[k]     <= tag_d[k];
         end
      end
   end

   assign ready_o       = en[0];
   assign valid_o       = valid_q[LAST];
   assign aluop_o       = aluop_q[LAST];
   assign illegal_o     = illegal_q[LAST];
   assign mext_o        = mext_q[LAST];
   assign tag_o         = tag_q[LAST];
   assign illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Directed bench for alu_ctrl_pipe: decode table, illegal counting, backpressure, flush, reset, M-ext.
// A second instance with CNT_W=2 shares all stimulus to observe counter saturation.
module tb_alu_ctrl_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       valid_i, ready_i, flush_i;
   logic [6:0] opcode_i, funct7_i;
   logic [4:0] tag_i;
   logic       ready_o, valid_o, illegal_o, mext_o;
   logic [2:0] aluop_o;
   logic [4:0] tag_o;
   logic [7:0] cnt_o;
   logic       ready2, valid2, illegal2, mext2;
   logic [2:0] aluop2;
   logic [4:0] tag2;
   logic [1:0] cnt2;

   int vectors = 0;
   int miscompares = 0;
   int exp_cnt = 0;

   logic [6:0] ops    [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h37, 7'h17};
   logic [2:0] exp_op [9] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd2, 3'd3, 3'd3, 3'd6, 3'd7};

`ifdef ALU_CTRL_MEXT_EN
   localparam logic EXP_MEXT = 1'b1;
   localparam logic EXP_ILL  = 1'b0;
`else
   localparam logic EXP_MEXT = 1'b0;
   localparam logic EXP_ILL  = 1'b1;
`endif

   always #5 clk = ~clk;

   alu_ctrl_pipe dut (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o),
      .opcode_i(opcode_i), .funct7_i(funct7_i), .tag_i(tag_i), .flush_i(flush_i),
      .valid_o(valid_o), .ready_i(ready_i), .aluop_o(aluop_o), .illegal_o(illegal_o),
      .mext_o(mext_o), .tag_o(tag_o), .illegal_cnt_o(cnt_o)
   );

   alu_ctrl_pipe #(.STAGES(2), .TAG_W(5), .CNT_W(2)) dut_sat (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready2),
      .opcode_i(opcode_i), .funct7_i(funct7_i), .tag_i(tag_i), .flush_i(flush_i),
      .valid_o(valid2), .ready_i(ready_i), .aluop_o(aluop2), .illegal_o(illegal2),
      .mext_o(mext2), .tag_o(tag2), .illegal_cnt_o(cnt2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [6:0] op, input logic [6:0] f7, input logic [4:0] tg);
      valid_i  = v;
      opcode_i = op;
      funct7_i = f7;
      tag_i    = tg;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b0, 7'h00, 7'h00, 5'h00);
      ready_i = 1'b1;
      flush_i = 1'b0;
      step();
      step();
      vectors++;
      if ({valid_o, aluop_o, illegal_o, mext_o, tag_o, cnt_o} !== 19'h0) begin
         miscompares++;
         $display("FAIL reset_outputs got v=%b op=%0d ill=%b mx=%b tag=%h cnt=%0d want all zero",
                  valid_o, aluop_o, illegal_o, mext_o, tag_o, cnt_o);
      end
      rst_n = 1'b1;
      #1;
      vectors++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release got ready=%b valid=%b want ready=1 valid=0", ready_o, valid_o);
      end
   endtask

   task automatic test_back_to_back();
      ready_i = 1'b1;
      for (int j = 0; j < 11; j++) begin
         if (j < 9) drive(1'b1, ops[j], 7'h00, 5'(j + 1));
         else       drive(1'b0, 7'h00, 7'h00, 5'h00);
         #1;
         vectors++;
         if (ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready j=%0d got %b want 1", j, ready_o);
         end
         step();
         vectors++;
         if (j >= 1 && j <= 9) begin
            if (valid_o !== 1'b1 || aluop_o !== exp_op[j-1] || tag_o !== 5'(j) || illegal_o !== 1'b0) begin
               miscompares++;
               $display("FAIL b2b_out j=%0d got v=%b op=%0d tag=%h ill=%b want v=1 op=%0d tag=%h ill=0",
                        j, valid_o, aluop_o, tag_o, illegal_o, exp_op[j-1], 5'(j));
            end
         end else if (valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle j=%0d got valid=%b want 0", j, valid_o);
         end
      end
   endtask

   task automatic test_illegal();
      ready_i = 1'b1;
      drive(1'b1, 7'h7F, 7'h00, 5'h1A);
      step();
      drive(1'b0, 7'h00, 7'h00, 5'h00);
      step();
      vectors++;
      if (valid_o !== 1'b1 || illegal_o !== 1'b1 || aluop_o !== 3'd0 || tag_o !== 5'h1A
          || cnt_o !== 8'(exp_cnt)) begin
         miscompares++;
         $display("FAIL illegal_out got v=%b ill=%b op=%0d tag=%h cnt=%0d want v=1 ill=1 op=0 tag=1a cnt=%0d",
                  valid_o, illegal_o, aluop_o, tag_o, cnt_o, exp_cnt);
      end
      step();
      exp_cnt++;
      vectors++;
      if (cnt_o !== 8'(exp_cnt) || valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL illegal_cnt got cnt=%0d v=%b want cnt=%0d v=0", cnt_o, valid_o, exp_cnt);
      end
   endtask

   task automatic test_backpressure();
      ready_i = 1'b0;
      drive(1'b1, 7'h33, 7'h00, 5'h01);
      step();
      vectors++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_first got ready=%b valid=%b want ready=1 valid=0", ready_o, valid_o);
      end
      drive(1'b1, 7'h03, 7'h00, 5'h02);
      step();
      drive(1'b1, 7'h37, 7'h00, 5'h03);
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (valid_o !== 1'b1 || tag_o !== 5'h01 || aluop_o !== 3'd0 || ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_hold i=%0d got v=%b tag=%h op=%0d ready=%b want v=1 tag=01 op=0 ready=0",
                     i, valid_o, tag_o, aluop_o, ready_o);
         end
         if (i < 3) step();
      end
      ready_i = 1'b1;
      #1;
      vectors++;
      if (ready_o !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_release_ready got %b want 1", ready_o);
      end
      step();
      drive(1'b0, 7'h00, 7'h00, 5'h00);
      vectors++;
      if (valid_o !== 1'b1 || tag_o !== 5'h02 || aluop_o !== 3'd4) begin
         miscompares++;
         $display("FAIL bp_second got v=%b tag=%h op=%0d want v=1 tag=02 op=4", valid_o, tag_o, aluop_o);
      end
      step();
      vectors++;
      if (valid_o !== 1'b1 || tag_o !== 5'h03 || aluop_o !== 3'd6) begin
         miscompares++;
         $display("FAIL bp_third got v=%b tag=%h op=%0d want v=1 tag=03 op=6", valid_o, tag_o, aluop_o);
      end
      step();
      vectors++;
      if (valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_drained got valid=%b want 0", valid_o);
      end
   endtask

   task automatic test_flush();
      ready_i = 1'b1;
      drive(1'b1, 7'h7F, 7'h00, 5'h04);
      step();
      drive(1'b1, 7'h13, 7'h00, 5'h05);
      step();
      vectors++;
      if (valid_o !== 1'b1 || tag_o !== 5'h04 || illegal_o !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_pre got v=%b tag=%h ill=%b want v=1 tag=04 ill=1", valid_o, tag_o, illegal_o);
      end
      flush_i = 1'b1;
      drive(1'b1, 7'h33, 7'h00, 5'h06);
      step();
      flush_i = 1'b0;
      drive(1'b0, 7'h00, 7'h00, 5'h00);
      vectors++;
      if (valid_o !== 1'b0 || cnt_o !== 8'(exp_cnt)) begin
         miscompares++;
         $display("FAIL flush_now got v=%b cnt=%0d want v=0 cnt=%0d", valid_o, cnt_o, exp_cnt);
      end
      for (int i = 0; i < 2; i++) begin
         step();
         vectors++;
         if (valid_o !== 1'b0 || cnt_o !== 8'(exp_cnt)) begin
            miscompares++;
            $display("FAIL flush_after i=%0d got v=%b cnt=%0d want v=0 cnt=%0d", i, valid_o, cnt_o, exp_cnt);
         end
      end
   endtask

   task automatic test_reset_midstream();
      ready_i = 1'b1;
      drive(1'b1, 7'h37, 7'h00, 5'h09);
      step();
      drive(1'b1, 7'h7F, 7'h00, 5'h0A);
      step();
      drive(1'b0, 7'h00, 7'h00, 5'h00);
      vectors++;
      if (valid_o !== 1'b1 || aluop_o !== 3'd6 || tag_o !== 5'h09) begin
         miscompares++;
         $display("FAIL rst_pre got v=%b op=%0d tag=%h want v=1 op=6 tag=09", valid_o, aluop_o, tag_o);
      end
      rst_n = 1'b0;
      #1;
      exp_cnt = 0;
      vectors++;
      if ({valid_o, aluop_o, illegal_o, mext_o, tag_o, cnt_o} !== 19'h0) begin
         miscompares++;
         $display("FAIL rst_async got v=%b op=%0d ill=%b mx=%b tag=%h cnt=%0d want all zero",
                  valid_o, aluop_o, illegal_o, mext_o, tag_o, cnt_o);
      end
      step();
      rst_n = 1'b1;
      #1;
      vectors++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_release got ready=%b valid=%b want ready=1 valid=0", ready_o, valid_o);
      end
      step();
      vectors++;
      if (valid_o !== 1'b0 || cnt_o !== 8'd0) begin
         miscompares++;
         $display("FAIL rst_discard got v=%b cnt=%0d want v=0 cnt=0", valid_o, cnt_o);
      end
   endtask

   task automatic test_saturation();
      int d;
      ready_i = 1'b1;
      for (int j = 0; j < 8; j++) begin
         if (j < 5) drive(1'b1, 7'h7F, 7'h00, 5'(j));
         else       drive(1'b0, 7'h00, 7'h00, 5'h00);
         step();
         d = (j < 2) ? 0 : ((j - 1 > 5) ? 5 : j - 1);
         vectors++;
         if (cnt_o !== 8'(d) || cnt2 !== 2'((d > 3) ? 3 : d)) begin
            miscompares++;
            $display("FAIL sat_cnt j=%0d got cnt8=%0d cnt2=%0d want cnt8=%0d cnt2=%0d",
                     j, cnt_o, cnt2, d, (d > 3) ? 3 : d);
         end
      end
      exp_cnt = 5;
   endtask

   task automatic test_mext();
      ready_i = 1'b1;
      drive(1'b1, 7'h33, 7'h01, 5'h07);
      step();
      drive(1'b1, 7'h33, 7'h20, 5'h08);
      step();
      drive(1'b0, 7'h00, 7'h00, 5'h00);
      vectors++;
      if (valid_o !== 1'b1 || tag_o !== 5'h07 || aluop_o !== 3'd0 || mext_o !== EXP_MEXT
          || illegal_o !== EXP_ILL) begin
         miscompares++;
         $display("FAIL mext_mul got v=%b tag=%h op=%0d mx=%b ill=%b want v=1 tag=07 op=0 mx=%b ill=%b",
                  valid_o, tag_o, aluop_o, mext_o, illegal_o, EXP_MEXT, EXP_ILL);
      end
      step();
      vectors++;
      if (valid_o !== 1'b1 || tag_o !== 5'h08 || aluop_o !== 3'd0 || mext_o !== 1'b0
          || illegal_o !== 1'b0) begin
         miscompares++;
         $display("FAIL mext_sub got v=%b tag=%h op=%0d mx=%b ill=%b want v=1 tag=08 op=0 mx=0 ill=0",
                  valid_o, tag_o, aluop_o, mext_o, illegal_o);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_illegal();
      test_backpressure();
      test_flush();
      test_reset_midstream();
      test_saturation();
      test_mext();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_ctrl_pipe.md
ALU_CTRL_PIPE -- requirements
Module: alu_ctrl_pipe

Interface
REQ-001 SHALL have parameter STAGES, default 2, number of register stages (legal 1..4).
REQ-002 SHALL have parameter TAG_W, default 5, width of the sideband tag carried with each instruction.
REQ-003 SHALL have parameter CNT_W, default 8, width of the illegal-instruction counter.
REQ-004 SHALL have port clk_i  input  1  the single clock; all state on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port valid_i  input  1  upstream instruction valid.
REQ-007 SHALL have port ready_o  output  1  block can accept an instruction this cycle.
REQ-008 SHALL have port opcode_i  input  7  instruction opcode field.
REQ-009 SHALL have port funct7_i  input  7  instruction funct7 field.
REQ-010 SHALL have port tag_i  input  TAG_W  sideband tag, passed through unmodified.
REQ-011 SHALL have port flush_i  input  1  synchronous kill of all in-flight entries.
REQ-012 SHALL have port valid_o  output  1  decoded result valid.
REQ-013 SHALL have port ready_i  input  1  downstream accepts the result.
REQ-014 SHALL have ports aluop_o output 3 (ALU operation class), illegal_o output 1 (unsupported opcode), mext_o output 1 (M-extension op), tag_o output TAG_W (tag of the presented result).
REQ-015 SHALL have port illegal_cnt_o  output  CNT_W  count of illegal instructions delivered.

Function
REQ-016 SHALL decode opcode_i to aluop: 0110011 R->000, 0010011 I->001, 1100011 BRANCH->010, 1100111 JALR->011, 1101111 JAL->011, 0000011 LOAD->100, 0100011 STORE->101, 0110111 LUI->110, 0010111 AUIPC->111.
REQ-017 SHALL, for any other opcode, set illegal=1 and aluop=000; aluop is never X.
REQ-018 SHALL decode at entry into stage 1 and carry {aluop, illegal, mext, tag} through all stages unchanged.
REQ-019 SHALL implement STAGES elastic stages, each with its own valid bit; stage k loads when stage k is empty or stage k advances this cycle.
REQ-020 SHALL drive ready_o = !v[1] || advance[1]; the last stage advances when valid_o && ready_i.
REQ-021 SHALL give latency exactly STAGES cycles from the valid_i&&ready_o handshake to valid_o with ready_i held 1, and sustain one instruction per cycle.
REQ-022 SHALL hold the output payload stable while valid_o=1 and ready_i=0; no entry is dropped or duplicated under backpressure.
REQ-023 SHALL, on flush_i=1, clear every stage valid at the next edge and ignore valid_i that cycle (flush wins over accept and advance); the counter does not count a result flushed in the same cycle.
REQ-024 SHALL increment illegal_cnt_o by 1 on each output handshake with illegal_o=1 and saturate at all-ones.
REQ-025 SHALL drive valid_o from the last-stage valid bit only; the payload outputs are don't-care to consumers when valid_o=0 but are reset-defined.

Reset
REQ-026 SHALL, while rst_ni=0, asynchronously clear all stage valids, aluop_o=000, illegal_o=0, mext_o=0, tag_o=0, illegal_cnt_o=0.
REQ-027 SHALL discard in-flight entries on reset mid-operation; ready_o=1 in the first cycle after reset release.

Configuration
REQ-028 SHALL, with ALU_CTRL_MEXT_EN defined, set mext=1 for opcode 0110011 with funct7_i=0000001 (aluop 000, illegal 0).
REQ-029 SHALL, without ALU_CTRL_MEXT_EN, treat opcode 0110011 with funct7_i=0000001 as illegal (illegal 1, mext 0, aluop 000); mext_o is tied 0.

Verification
REQ-030 SHALL cover: STAGES=2, ready_i=1, back-to-back R,I,LOAD,STORE,BRANCH,JALR,JAL,LUI,AUIPC -> aluop 000,001,100,101,010,011,011,110,111 each 2 cycles after accept, one per cycle.
REQ-031 SHALL cover: opcode 1111111 tag 5'h1A -> illegal_o=1, aluop_o=000, tag_o=5'h1A, illegal_cnt_o 0->1 after handshake.
REQ-032 SHALL cover: ready_i=0 for 5 cycles with 3 instructions sent -> STAGES entries held, ready_o=0 when full, all 3 delivered in order once ready_i=1.
REQ-033 SHALL cover: flush_i=1 with 2 entries in flight and valid_i=1 -> valid_o=0 next cycle, neither entry nor new input delivered, counter unchanged.
REQ-034 SHALL cover: CNT_W=2, 5 illegal deliveries -> illegal_cnt_o saturates at 3.
REQ-035 SHALL cover: rst_ni pulled low mid-stream -> outputs zero immediately; with and without ALU_CTRL_MEXT_EN, funct7=0000001 R-type -> mext_o=1/illegal_o=0 versus mext_o=0/illegal_o=1.
